// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared constants and enums for the register-bank write path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;

   localparam logic [REG_AW-1:0] R0 = '0;

   typedef enum logic [1:0] {
      REQ_ALU      = 2'd0,
      REQ_LOAD     = 2'd1,
      REQ_PREFETCH = 2'd2
   } req_idx_e;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Rotating-priority encoder: first set request at or after ptr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_onehot,
   output logic [PW-1:0]   o_idx,
   output logic            o_valid
);

   int w_pos;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_pos    = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= NREQ) begin
            w_pos = w_pos - NREQ;
         end
         if (!o_valid && i_req[w_pos]) begin
            o_valid         = 1'b1;
            o_onehot[w_pos] = 1'b1;
            o_idx           = PW'(w_pos);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
//  Module   : regfile_wr_arbiter
//  Purpose  : Round-robin sharing of the register-bank write port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int DW   = REG_DW,
   parameter int AW   = REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic              hold,
   output logic [NREQ-1:0]   gnt,
   output logic              we_o,
   output logic [AW-1:0]     waddr_o,
   output logic [DW-1:0]     wdata_o,
   output logic              busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e      r_state;
   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] w_win;
   logic [PW-1:0]   w_idx;
   logic            w_valid;
   logic            w_grant;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_data;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_win),
      .o_idx    (w_idx),
      .o_valid  (w_valid)
   );

   // HOLD state keeps grants blocked for one cycle after hold drops.
   assign w_grant = w_valid && (r_state == ARB) && !hold && rst_n;
   assign gnt     = w_grant ? w_win : '0;
   assign busy    = |(req & ~gnt);
   assign w_addr  = req_addr[int'(w_idx)*AW +: AW];
   assign w_data  = req_data[int'(w_idx)*DW +: DW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB;
         r_ptr   <= '0;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         case (r_state)
            ARB:     if (hold)  r_state <= HOLD;
            HOLD:    if (!hold) r_state <= ARB;
            default: r_state <= ARB;
         endcase

         we_o <= 1'b0;
         if (w_grant) begin
            waddr_o <= w_addr;
            wdata_o <= w_data;
            // r0 writes are consumed but never reach the bank
            we_o    <= (w_addr != AW'(R0));
            r_ptr   <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
//  Module   : tb_regfile_wr_arbiter
//  Purpose  : Self-checking bench for regfile_wr_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic              hold = 1'b0;
   logic [N-1:0]      gnt;
   logic              we_o;
   logic [AW-1:0]     waddr_o;
   logic [DW-1:0]     wdata_o;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            m_ptr;
   logic          m_hold_prev;
   logic          e_we;
   logic [AW-1:0] e_waddr;
   logic [DW-1:0] e_wdata;
   logic [DW-1:0] dut_bank [32];

   regfile_wr_arbiter #(.NREQ(N), .DW(DW), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_addr (req_addr),
      .req_data (req_data),
      .hold     (hold),
      .gnt      (gnt),
      .we_o     (we_o),
      .waddr_o  (waddr_o),
      .wdata_o  (wdata_o),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] r;
      r = '0;
      if (rst_n && !hold && !m_hold_prev) begin
         for (int k = 0; k < N; k++) begin
            if (r == '0 && req[(m_ptr + k) % N]) r[(m_ptr + k) % N] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_hold_prev = 1'b0;
      e_we = 1'b0; e_waddr = '0; e_wdata = '0;
   endtask

   task automatic model_advance();
      logic [N-1:0] g;
      logic [AW-1:0] a;
      g = exp_gnt();
      e_we = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            a       = req_addr[i*AW +: AW];
            e_waddr = a;
            e_wdata = req_data[i*DW +: DW];
            e_we    = (a != '0);
            m_ptr   = (i + 1) % N;
         end
      end
      m_hold_prev = hold;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic half();
      @(negedge clk);
      if (we_o) dut_bank[waddr_o] = wdata_o;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_advance();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; hold = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      req = 3'b001; set_req(0, 5'd3, 32'h55);
      half(); tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (we_o !== 1'b0 || waddr_o !== '0 || wdata_o !== '0 || gnt !== '0) begin
         errors++;
         $display("FAIL reset_async: we=%b addr=%0d data=%h gnt=%b, required all zero",
                  we_o, waddr_o, wdata_o, gnt);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      req = 3'b010; set_req(1, 5'd4, 32'h66);
      #1;
      checks++;
      if (gnt !== 3'b010) begin
         errors++; $display("FAIL reset_first_gnt: gnt=%b required 010", gnt);
      end
      tick();
      req = 3'b111;
      half();
      checks++;
      if (gnt !== 3'b100) begin
         errors++; $display("FAIL reset_ptr2: gnt=%b required 100", gnt);
      end
      tick();
      req = '0;
   endtask

   task automatic test_single_write();
      do_reset();
      req = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
      half();
      checks++;
      if (gnt !== 3'b001) begin
         errors++; $display("FAIL single_gnt: gnt=%b required 001", gnt);
      end
      tick();
      req = '0;
      half();
      checks++;
      if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_write: we=%b addr=%0d data=%h required 1/5/deadbeef",
                  we_o, waddr_o, wdata_o);
      end
      tick();
      half();
      checks++;
      if (we_o !== 1'b0 || waddr_o !== 5'd5) begin
         errors++; $display("FAIL single_idle: we=%b addr=%0d required 0/5", we_o, waddr_o);
      end
      tick();
   endtask

   task automatic test_contention();
      int seq [6] = '{0, 1, 2, 0, 1, 2};
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, AW'(10 + i), 32'hC0 + i);
      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         half();
         checks++;
         if (gnt !== (3'b001 << seq[k]) || (k > 0 && we_o !== 1'b1)) begin
            errors++;
            $display("FAIL contention_%0d: gnt=%b we=%b required gnt=%b we=%b",
                     k, gnt, we_o, 3'b001 << seq[k], k > 0);
         end
         tick();
      end
      req = '0;
      half();
      checks++;
      if (we_o !== 1'b1 || waddr_o !== 5'd12 || gnt !== '0) begin
         errors++; $display("FAIL contention_last: we=%b addr=%0d gnt=%b", we_o, waddr_o, gnt);
      end
      tick(); half();
      checks++;
      if (we_o !== 1'b0) begin
         errors++; $display("FAIL contention_end: we=%b required 0", we_o);
      end
      tick();
   endtask

   task automatic test_r0_discard();
      do_reset();
      req = 3'b010; set_req(1, 5'd0, 32'h1234);
      half();
      checks++;
      if (gnt !== 3'b010) begin
         errors++; $display("FAIL r0_gnt: gnt=%b required 010", gnt);
      end
      tick();
      req = 3'b111;
      for (int i = 0; i < N; i++) if (i != 1) set_req(i, 5'd9, 32'h99);
      half();
      checks++;
      if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'h1234) begin
         errors++;
         $display("FAIL r0_write: we=%b addr=%0d data=%h required 0/0/1234", we_o, waddr_o, wdata_o);
      end
      checks++;
      if (gnt !== 3'b100) begin
         errors++; $display("FAIL r0_ptr: gnt=%b required 100", gnt);
      end
      tick();
      req = '0;
   endtask

   task automatic test_hold();
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, AW'(20 + i), 32'hB0 + i);
      req = 3'b100;
      half();
      checks++;
      if (gnt !== 3'b100) begin
         errors++; $display("FAIL hold_pre: gnt=%b required 100", gnt);
      end
      tick();
      req = 3'b101; hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         half();
         checks++;
         if (gnt !== '0 || busy !== 1'b1 || (k == 0 && we_o !== 1'b1)) begin
            errors++;
            $display("FAIL hold_%0d: gnt=%b busy=%b we=%b", k, gnt, busy, we_o);
         end
         tick();
      end
      hold = 1'b0;
      half();
      checks++;
      if (gnt !== '0 || busy !== 1'b1) begin
         errors++; $display("FAIL hold_release: gnt=%b busy=%b required 000/1", gnt, busy);
      end
      tick();
      half();
      checks++;
      if (gnt !== 3'b001) begin
         errors++; $display("FAIL hold_after: gnt=%b required 001", gnt);
      end
      tick();
      req = '0;
   endtask

   task automatic test_same_addr();
      do_reset();
      dut_bank[7] = '0;
      req = 3'b010; set_req(1, 5'd9, 32'h9);
      half(); tick();
      req = 3'b101; set_req(0, 5'd7, 32'hA); set_req(2, 5'd7, 32'hB);
      half();
      checks++;
      if (gnt !== 3'b100) begin
         errors++; $display("FAIL same_first: gnt=%b required 100", gnt);
      end
      tick();
      req = 3'b001;
      half();
      checks++;
      if (gnt !== 3'b001 || wdata_o !== 32'hB) begin
         errors++; $display("FAIL same_second: gnt=%b data=%h required 001/b", gnt, wdata_o);
      end
      tick();
      req = '0;
      half(); tick(); half();
      checks++;
      if (dut_bank[7] !== 32'hA) begin
         errors++; $display("FAIL same_final: r7=%h required a", dut_bank[7]);
      end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] eg;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         req  = N'($urandom);
         hold = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < N; i++)
            set_req(i, ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom), $urandom);
         half();
         eg = exp_gnt();
         checks++;
         if (gnt !== eg || busy !== |(req & ~eg)) begin
            errors++; $display("FAIL rand_gnt_%0d: gnt=%b busy=%b required %b/%b",
                               c, gnt, busy, eg, |(req & ~eg));
         end
         checks++;
         if (we_o !== e_we || waddr_o !== e_waddr || wdata_o !== e_wdata) begin
            errors++; $display("FAIL rand_out_%0d: we=%b addr=%0d data=%h required %b/%0d/%h",
                               c, we_o, waddr_o, wdata_o, e_we, e_waddr, e_wdata);
         end
         tick();
      end
      req = '0; hold = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_write();
      test_contention();
      test_r0_discard();
      test_hold();
      test_same_addr();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
